// File: rtl/riscv_bus_arbiter.sv
// riscv_bus_arbiter: shares one bus device port between NrHosts hosts and routes in-order responses back.
// Define RV_ARB_ROUND_ROBIN_EN for round-robin priority; otherwise the lowest requesting index wins.
module riscv_bus_arbiter #(
  parameter int NrHosts        = 3,
  parameter int MaxOutstanding = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NrHosts-1:0]      host_req_i,
  input  logic [NrHosts-1:0]      host_we_i,
  input  logic [NrHosts*32-1:0]   host_addr_i,
  input  logic [NrHosts*32-1:0]   host_wdata_i,
  input  logic [NrHosts*4-1:0]    host_be_i,
  output logic [NrHosts-1:0]      host_gnt_o,
  output logic [NrHosts-1:0]      host_rvalid_o,
  output logic [31:0]             host_rdata_o,
  output logic                    host_err_o,
  output logic                    dev_req_o,
  output logic                    dev_we_o,
  output logic [31:0]             dev_addr_o,
  output logic [31:0]             dev_wdata_o,
  output logic [3:0]              dev_be_o,
  input  logic                    dev_gnt_i,
  input  logic                    dev_rvalid_i,
  input  logic [31:0]             dev_rdata_i,
  input  logic                    dev_err_i
);
  localparam int IdxW = $clog2(NrHosts);
  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);

  logic [IdxW-1:0] r_fifo [MaxOutstanding];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [CntW-1:0] r_count;
  logic            r_locked;
  logic [IdxW-1:0] r_lock_idx;

  logic [IdxW-1:0] w_arb_idx;
  logic [IdxW-1:0] w_winner;
  logic [IdxW-1:0] w_head;
  logic            w_found;
  logic            w_dev_req;
  logic            w_grant;
  logic            w_pop;

`ifdef RV_ARB_ROUND_ROBIN_EN
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NrHosts - 1);
  logic [IdxW-1:0] r_rr_ptr;

  // Search starts at the host after the last one granted, wrapping modulo NrHosts.
  always_comb begin
    w_arb_idx = '0;
    w_found   = 1'b0;
    for (int k = 0; k < NrHosts; k++) begin
      if (!w_found && host_req_i[(int'(r_rr_ptr) + k) % NrHosts]) begin
        w_arb_idx = IdxW'((int'(r_rr_ptr) + k) % NrHosts);
        w_found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rr_ptr <= '0;
    end else if (w_grant) begin
      r_rr_ptr <= (w_winner == LastIdx) ? '0 : w_winner + 1'b1;
    end
  end
`else
  always_comb begin
    w_arb_idx = '0;
    w_found   = 1'b0;
    for (int k = 0; k < NrHosts; k++) begin
      if (!w_found && host_req_i[k]) begin
        w_arb_idx = IdxW'(k);
        w_found   = 1'b1;
      end
    end
  end
`endif

  // A request left waiting on dev_gnt_i keeps the bus so the device sees stable fields.
  assign w_winner  = r_locked ? r_lock_idx : w_arb_idx;
  assign w_dev_req = rst_ni & (|host_req_i) & (r_count < MaxCnt);
  assign w_grant   = w_dev_req & dev_gnt_i;
  assign w_head    = r_fifo[r_rptr];
  assign w_pop     = rst_ni & dev_rvalid_i & (r_count != '0);

  always_comb begin
    dev_req_o     = w_dev_req;
    dev_we_o      = 1'b0;
    dev_addr_o    = '0;
    dev_wdata_o   = '0;
    dev_be_o      = '0;
    host_gnt_o    = '0;
    host_rvalid_o = '0;
    if (w_dev_req) begin
      dev_we_o             = host_we_i[w_winner];
      dev_addr_o           = host_addr_i[32*int'(w_winner) +: 32];
      dev_wdata_o          = host_wdata_i[32*int'(w_winner) +: 32];
      dev_be_o             = host_be_i[4*int'(w_winner) +: 4];
      host_gnt_o[w_winner] = dev_gnt_i;
    end
    if (w_pop) begin
      host_rvalid_o[w_head] = 1'b1;
    end
    host_rdata_o = rst_ni ? dev_rdata_i : '0;
    host_err_o   = rst_ni & dev_err_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_locked   <= 1'b0;
      r_lock_idx <= '0;
      for (int i = 0; i < MaxOutstanding; i++) begin
        r_fifo[i] <= '0;
      end
    end else begin
      if (w_grant) begin
        r_fifo[r_wptr] <= w_winner;
        r_wptr         <= (r_wptr == LastPtr) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == LastPtr) ? '0 : r_rptr + 1'b1;
      end
      if (w_grant && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_grant && w_pop) begin
        r_count <= r_count - 1'b1;
      end
      r_locked   <= w_dev_req & ~dev_gnt_i;
      r_lock_idx <= w_winner;
    end
  end

`ifndef SYNTHESIS
  // Responses with nothing outstanding are dropped; flag them in simulation.
  always_ff @(posedge clk_i) begin
    if (rst_ni && dev_rvalid_i && (r_count == '0)) begin
      $error("riscv_bus_arbiter: device response with no outstanding transaction dropped");
    end
  end
`endif

endmodule

// File: tb/tb_riscv_bus_arbiter.sv
// Testbench for riscv_bus_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_riscv_bus_arbiter;
  localparam int NrHosts = 3;
  localparam int MaxOut  = 2;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic [NrHosts-1:0]    host_req_i;
  logic [NrHosts-1:0]    host_we_i;
  logic [NrHosts*32-1:0] host_addr_i;
  logic [NrHosts*32-1:0] host_wdata_i;
  logic [NrHosts*4-1:0]  host_be_i;
  logic [NrHosts-1:0]    host_gnt_o;
  logic [NrHosts-1:0]    host_rvalid_o;
  logic [31:0]           host_rdata_o;
  logic                  host_err_o;
  logic                  dev_req_o;
  logic                  dev_we_o;
  logic [31:0]           dev_addr_o;
  logic [31:0]           dev_wdata_o;
  logic [3:0]            dev_be_o;
  logic                  dev_gnt_i;
  logic                  dev_rvalid_i;
  logic [31:0]           dev_rdata_i;
  logic                  dev_err_i;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: outstanding host indices in grant order, lock owner, rr pointer.
  logic [1:0] exp_q[$];
  int         m_lock;
  int         m_rr;

  riscv_bus_arbiter #(.NrHosts(NrHosts), .MaxOutstanding(MaxOut)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i),
    .host_wdata_i(host_wdata_i), .host_be_i(host_be_i),
    .host_gnt_o(host_gnt_o), .host_rvalid_o(host_rvalid_o),
    .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
    .dev_req_o(dev_req_o), .dev_we_o(dev_we_o), .dev_addr_o(dev_addr_o),
    .dev_wdata_o(dev_wdata_o), .dev_be_o(dev_be_o), .dev_gnt_i(dev_gnt_i),
    .dev_rvalid_i(dev_rvalid_i), .dev_rdata_i(dev_rdata_i), .dev_err_i(dev_err_i)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks: inputs change 1ns after posedge, outputs are checked at the following negedge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    host_req_i   = '0;
    host_we_i    = '0;
    host_addr_i  = '0;
    host_wdata_i = '0;
    host_be_i    = '0;
    dev_gnt_i    = 1'b0;
    dev_rvalid_i = 1'b0;
    dev_rdata_i  = '0;
    dev_err_i    = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
  endtask

  function automatic int model_winner(logic [NrHosts-1:0] req);
    if (m_lock >= 0) return m_lock;
`ifdef RV_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < NrHosts; k++)
      if (req[(m_rr + k) % NrHosts]) return (m_rr + k) % NrHosts;
`else
    for (int k = 0; k < NrHosts; k++)
      if (req[k]) return k;
`endif
    return 0;
  endfunction

  task automatic test_reset();
    rst_ni       = 1'b0;
    host_req_i   = '1;
    host_we_i    = '1;
    host_addr_i  = {32'h3333_0000, 32'h2222_0000, 32'h1111_0000};
    host_wdata_i = {32'hAAAA_0003, 32'hAAAA_0002, 32'hAAAA_0001};
    host_be_i    = '1;
    dev_gnt_i    = 1'b1;
    dev_rvalid_i = 1'b1;
    dev_rdata_i  = 32'h1234_5678;
    dev_err_i    = 1'b1;
    #4;
    n_vec++; if (dev_req_o !== 1'b0) begin n_err++; $display("FAIL reset_dev_req: got %b expected 0", dev_req_o); end
    n_vec++; if (host_gnt_o !== '0) begin n_err++; $display("FAIL reset_gnt: got %b expected 000", host_gnt_o); end
    n_vec++; if (host_rvalid_o !== '0) begin n_err++; $display("FAIL reset_rvalid: got %b expected 000", host_rvalid_o); end
    n_vec++; if ({dev_we_o, dev_addr_o, dev_wdata_o, dev_be_o} !== '0) begin n_err++; $display("FAIL reset_dev_fields: got %b %h %h %h expected all 0", dev_we_o, dev_addr_o, dev_wdata_o, dev_be_o); end
    n_vec++; if ({host_rdata_o, host_err_o} !== '0) begin n_err++; $display("FAIL reset_resp: got %h %b expected 0 0", host_rdata_o, host_err_o); end
    tick();
    rst_ni = 1'b1;
    clear_inputs();
    #4;
    n_vec++; if ({dev_req_o, host_gnt_o, host_rvalid_o} !== '0) begin n_err++; $display("FAIL reset_idle: got %b %b %b expected 0", dev_req_o, host_gnt_o, host_rvalid_o); end
    tick();
  endtask

  task automatic test_single_host();
    do_reset();
    host_req_i  = 3'b010;
    host_addr_i = {32'h0, 32'h0000_0100, 32'h0};
    host_be_i   = 12'h0F0;
    dev_gnt_i   = 1'b1;
    #4;
    n_vec++; if (host_gnt_o !== 3'b010) begin n_err++; $display("FAIL single_gnt: got %b expected 010", host_gnt_o); end
    n_vec++; if ({dev_req_o, dev_we_o, dev_addr_o, dev_be_o} !== {1'b1, 1'b0, 32'h100, 4'hF}) begin n_err++; $display("FAIL single_fwd: got %b %b %h %h expected 1 0 100 f", dev_req_o, dev_we_o, dev_addr_o, dev_be_o); end
    tick();
    clear_inputs();
    dev_rvalid_i = 1'b1;
    dev_rdata_i  = 32'hCAFE_0001;
    #4;
    n_vec++; if (host_rvalid_o !== 3'b010) begin n_err++; $display("FAIL single_rvalid: got %b expected 010", host_rvalid_o); end
    n_vec++; if (host_rdata_o !== 32'hCAFE_0001) begin n_err++; $display("FAIL single_rdata: got %h expected cafe0001", host_rdata_o); end
    tick();
    clear_inputs();
  endtask

  task automatic test_contention();
    logic [NrHosts-1:0] exp_g;
    logic [NrHosts-1:0] prev_g;
    logic [31:0]        exp_a;
    do_reset();
    prev_g = '0;
    for (int c = 0; c < 6; c++) begin
      host_req_i   = 3'b101;
      host_addr_i  = {32'h3000, 32'h2000, 32'h1000};
      dev_gnt_i    = 1'b1;
      dev_rvalid_i = (c > 0);
      dev_rdata_i  = 32'(c);
`ifdef RV_ARB_ROUND_ROBIN_EN
      exp_g = (c % 2 == 0) ? 3'b001 : 3'b100;
`else
      exp_g = 3'b001;
`endif
      exp_a = (exp_g == 3'b001) ? 32'h1000 : 32'h3000;
      #4;
      n_vec++; if (host_gnt_o !== exp_g) begin n_err++; $display("FAIL contention_gnt c=%0d: got %b expected %b", c, host_gnt_o, exp_g); end
      n_vec++; if (dev_addr_o !== exp_a) begin n_err++; $display("FAIL contention_addr c=%0d: got %h expected %h", c, dev_addr_o, exp_a); end
      n_vec++; if (host_rvalid_o !== prev_g) begin n_err++; $display("FAIL contention_rvalid c=%0d: got %b expected %b", c, host_rvalid_o, prev_g); end
      prev_g = exp_g;
      tick();
    end
    clear_inputs();
    dev_rvalid_i = 1'b1;
    #4;
    n_vec++; if (host_rvalid_o !== prev_g) begin n_err++; $display("FAIL contention_drain: got %b expected %b", host_rvalid_o, prev_g); end
    tick();
    clear_inputs();
  endtask

  task automatic test_lock();
    do_reset();
    host_addr_i = {32'h0000_0200, 32'h0, 32'h0000_0300};
    host_req_i  = 3'b100;
    dev_gnt_i   = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #4;
      n_vec++; if ({dev_req_o, dev_addr_o, host_gnt_o} !== {1'b1, 32'h200, 3'b000}) begin n_err++; $display("FAIL lock_wait c=%0d: got %b %h %b expected 1 200 000", c, dev_req_o, dev_addr_o, host_gnt_o); end
      tick();
    end
    host_req_i = 3'b101;
    #4;
    n_vec++; if ({dev_addr_o, host_gnt_o} !== {32'h200, 3'b000}) begin n_err++; $display("FAIL lock_hold: got %h %b expected 200 000", dev_addr_o, host_gnt_o); end
    tick();
    dev_gnt_i = 1'b1;
    #4;
    n_vec++; if ({dev_addr_o, host_gnt_o} !== {32'h200, 3'b100}) begin n_err++; $display("FAIL lock_grant: got %h %b expected 200 100", dev_addr_o, host_gnt_o); end
    tick();
    host_req_i   = 3'b001;
    dev_rvalid_i = 1'b1;
    #4;
    n_vec++; if ({dev_addr_o, host_gnt_o, host_rvalid_o} !== {32'h300, 3'b001, 3'b100}) begin n_err++; $display("FAIL lock_next: got %h %b %b expected 300 001 100", dev_addr_o, host_gnt_o, host_rvalid_o); end
    tick();
    host_req_i = 3'b000;
    #4;
    n_vec++; if (host_rvalid_o !== 3'b001) begin n_err++; $display("FAIL lock_resp: got %b expected 001", host_rvalid_o); end
    tick();
    clear_inputs();
  endtask

  task automatic test_fifo_full();
    logic [5:0] exp_req;
    do_reset();
    host_req_i  = 3'b001;
    host_addr_i = {32'h0, 32'h0, 32'h0000_0040};
    dev_gnt_i   = 1'b1;
    exp_req     = 6'b100011;  // cycle 0 in bit 0
    for (int c = 0; c < 6; c++) begin
      dev_rvalid_i = (c == 4);
      #4;
      n_vec++; if (dev_req_o !== exp_req[c]) begin n_err++; $display("FAIL full_dev_req c=%0d: got %b expected %b", c, dev_req_o, exp_req[c]); end
      n_vec++; if (host_gnt_o !== (exp_req[c] ? 3'b001 : 3'b000)) begin n_err++; $display("FAIL full_gnt c=%0d: got %b expected %b", c, host_gnt_o, exp_req[c]); end
      if (c == 4) begin
        n_vec++; if (host_rvalid_o !== 3'b001) begin n_err++; $display("FAIL full_pop: got %b expected 001", host_rvalid_o); end
      end
      tick();
    end
    host_req_i   = '0;
    dev_rvalid_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #4;
      n_vec++; if (host_rvalid_o !== 3'b001) begin n_err++; $display("FAIL full_drain c=%0d: got %b expected 001", c, host_rvalid_o); end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_ordering();
    do_reset();
    host_addr_i = {32'h0, 32'h0000_0010, 32'h0000_0020};
    host_req_i  = 3'b010;
    dev_gnt_i   = 1'b1;
    #4;
    n_vec++; if (host_gnt_o !== 3'b010) begin n_err++; $display("FAIL order_gnt1: got %b expected 010", host_gnt_o); end
    tick();
    host_req_i = 3'b001;
    #4;
    n_vec++; if (host_gnt_o !== 3'b001) begin n_err++; $display("FAIL order_gnt0: got %b expected 001", host_gnt_o); end
    tick();
    clear_inputs();
    dev_rvalid_i = 1'b1;
    dev_rdata_i  = 32'hA;
    #4;
    n_vec++; if ({host_rvalid_o, host_rdata_o, host_err_o} !== {3'b010, 32'hA, 1'b0}) begin n_err++; $display("FAIL order_resp1: got %b %h %b expected 010 a 0", host_rvalid_o, host_rdata_o, host_err_o); end
    tick();
    dev_rdata_i = 32'hB;
    dev_err_i   = 1'b1;
    #4;
    n_vec++; if ({host_rvalid_o, host_rdata_o, host_err_o} !== {3'b001, 32'hB, 1'b1}) begin n_err++; $display("FAIL order_resp2: got %b %h %b expected 001 b 1", host_rvalid_o, host_rdata_o, host_err_o); end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    host_req_i  = 3'b010;
    host_addr_i = {32'h0000_0700, 32'h0000_0500, 32'h0};
    dev_gnt_i   = 1'b1;
    #4;
    n_vec++; if (host_gnt_o !== 3'b010) begin n_err++; $display("FAIL midrst_gnt: got %b expected 010", host_gnt_o); end
    tick();
    rst_ni       = 1'b0;
    host_req_i   = 3'b111;
    dev_rvalid_i = 1'b1;
    dev_rdata_i  = 32'hDEAD_BEEF;
    dev_err_i    = 1'b1;
    #4;
    n_vec++; if ({dev_req_o, host_gnt_o, host_rvalid_o, dev_addr_o, host_rdata_o, host_err_o} !== '0) begin n_err++; $display("FAIL midrst_outputs: got %b %b %b %h %h %b expected all 0", dev_req_o, host_gnt_o, host_rvalid_o, dev_addr_o, host_rdata_o, host_err_o); end
    tick();
    rst_ni = 1'b1;
    clear_inputs();
    host_req_i  = 3'b100;
    host_addr_i = {32'h0000_0700, 32'h0000_0500, 32'h0};
    dev_gnt_i   = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #4;
      n_vec++; if (host_gnt_o !== ((c < 2) ? 3'b100 : 3'b000)) begin n_err++; $display("FAIL midrst_refill c=%0d: got %b expected %b", c, host_gnt_o, (c < 2) ? 3'b100 : 3'b000); end
      tick();
    end
    clear_inputs();
    dev_rvalid_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #4;
      n_vec++; if (host_rvalid_o !== 3'b100) begin n_err++; $display("FAIL midrst_route c=%0d: got %b expected 100", c, host_rvalid_o); end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_random();
    logic               p_req [NrHosts];
    logic               p_we [NrHosts];
    logic [31:0]        p_addr [NrHosts];
    logic [31:0]        p_wdata [NrHosts];
    logic [3:0]         p_be [NrHosts];
    logic               e_req;
    logic               e_we;
    logic [31:0]        e_addr;
    logic [31:0]        e_wdata;
    logic [3:0]         e_be;
    logic [NrHosts-1:0] e_gnt;
    logic [NrHosts-1:0] e_rv;
    int                 w;
    do_reset();
    exp_q.delete();
    m_lock = -1;
    m_rr   = 0;
    for (int h = 0; h < NrHosts; h++) p_req[h] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int h = 0; h < NrHosts; h++) begin
        if (!p_req[h] && $urandom_range(0, 2) == 0) begin
          p_req[h]   = 1'b1;
          p_we[h]    = 1'($urandom_range(0, 1));
          p_addr[h]  = $urandom;
          p_wdata[h] = $urandom;
          p_be[h]    = 4'($urandom_range(0, 15));
        end
        host_req_i[h]            = p_req[h];
        host_we_i[h]             = p_req[h] ? p_we[h] : 1'b0;
        host_addr_i[32*h +: 32]  = p_req[h] ? p_addr[h] : 32'h0;
        host_wdata_i[32*h +: 32] = p_req[h] ? p_wdata[h] : 32'h0;
        host_be_i[4*h +: 4]      = p_req[h] ? p_be[h] : 4'h0;
      end
      dev_gnt_i    = ($urandom_range(0, 3) != 0);
      dev_rvalid_i = (exp_q.size() > 0) && ($urandom_range(0, 2) != 0);
      dev_rdata_i  = $urandom;
      dev_err_i    = 1'($urandom_range(0, 1));
      w       = model_winner(host_req_i);
      e_req   = (host_req_i != '0) && (exp_q.size() < MaxOut);
      e_we    = 1'b0;
      e_addr  = '0;
      e_wdata = '0;
      e_be    = '0;
      e_gnt   = '0;
      e_rv    = '0;
      if (e_req) begin
        e_we    = p_we[w];
        e_addr  = p_addr[w];
        e_wdata = p_wdata[w];
        e_be    = p_be[w];
        if (dev_gnt_i) e_gnt[w] = 1'b1;
      end
      if (dev_rvalid_i) e_rv[exp_q[0]] = 1'b1;
      #4;
      n_vec++; if (dev_req_o !== e_req) begin n_err++; $display("FAIL rand_dev_req c=%0d: got %b expected %b", c, dev_req_o, e_req); end
      n_vec++; if (host_gnt_o !== e_gnt) begin n_err++; $display("FAIL rand_gnt c=%0d: got %b expected %b", c, host_gnt_o, e_gnt); end
      n_vec++; if ({dev_we_o, dev_addr_o, dev_wdata_o, dev_be_o} !== {e_we, e_addr, e_wdata, e_be}) begin n_err++; $display("FAIL rand_fwd c=%0d: got %b %h %h %h expected %b %h %h %h", c, dev_we_o, dev_addr_o, dev_wdata_o, dev_be_o, e_we, e_addr, e_wdata, e_be); end
      n_vec++; if (host_rvalid_o !== e_rv) begin n_err++; $display("FAIL rand_rvalid c=%0d: got %b expected %b", c, host_rvalid_o, e_rv); end
      n_vec++; if ({host_rdata_o, host_err_o} !== {dev_rdata_i, dev_err_i}) begin n_err++; $display("FAIL rand_rdata c=%0d: got %h %b expected %h %b", c, host_rdata_o, host_err_o, dev_rdata_i, dev_err_i); end
      if (dev_rvalid_i) void'(exp_q.pop_front());
      if (e_gnt != '0) begin
        exp_q.push_back(2'(w));
        p_req[w] = 1'b0;
        m_rr     = (w + 1) % NrHosts;
      end
      m_lock = (e_req && !dev_gnt_i) ? w : -1;
      tick();
    end
    clear_inputs();
    for (int c = 0; c < MaxOut && exp_q.size() > 0; c++) begin
      dev_rvalid_i = 1'b1;
      e_rv = '0;
      e_rv[exp_q[0]] = 1'b1;
      #4;
      n_vec++; if (host_rvalid_o !== e_rv) begin n_err++; $display("FAIL rand_drain c=%0d: got %b expected %b", c, host_rvalid_o, e_rv); end
      void'(exp_q.pop_front());
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst_ni = 1'b0;
    tick();
    test_reset();
    test_single_host();
    test_contention();
    test_lock();
    test_fifo_full();
    test_ordering();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
